// File: rtl/video_timing_gen.sv
// 720p60 video timing and test-pattern source: active-high syncs and a registered RGB/sync/blank output stage.
// Video outputs are registered one cycle behind the h/v counters. Run/stop control lets the current frame finish cleanly.
module video_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    input  logic [1:0]  pattern,
    output logic [7:0]  out_red,
    output logic [7:0]  out_green,
    output logic [7:0]  out_blue,
    output logic        out_hsync,
    output logic        out_vsync,
    output logic        out_blank,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic        running
);

    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST     = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state;
    logic [10:0] h;
    logic [9:0]  v;
    logic [1:0]  pat_q;

    logic        first_px;
    logic        h_end;
    logic        v_end;
    logic        active;
    logic        hsync_nx;
    logic        vsync_nx;
    logic [1:0]  pat_sel;
    logic [15:0] cnt_nx;
    logic [2:0]  bar;
    logic [23:0] rgb_nx;

    // At the first pixel the new pattern and the incremented count take effect on that same output cycle
    always_comb begin
        first_px = (state == RUN) && (h == 11'd0) && (v == 10'd0);
        h_end    = (h == H_LAST);
        v_end    = (v == V_LAST);
        active   = (h < H_ACT_END) && (v < V_ACT_END);
        hsync_nx = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
        vsync_nx = (v >= V_SYNC_BEG) && (v < V_SYNC_END);
        pat_sel  = first_px ? pattern : pat_q;
        cnt_nx   = first_px ? frame_cnt + 16'd1 : frame_cnt;

        if (h >= 11'd1120)      bar = 3'd7;
        else if (h >= 11'd960)  bar = 3'd6;
        else if (h >= 11'd800)  bar = 3'd5;
        else if (h >= 11'd640)  bar = 3'd4;
        else if (h >= 11'd480)  bar = 3'd3;
        else if (h >= 11'd320)  bar = 3'd2;
        else if (h >= 11'd160)  bar = 3'd1;
        else                    bar = 3'd0;

        rgb_nx = 24'h000000;
        if (active) begin
            case (pat_sel)
                2'd0:    rgb_nx = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
                2'd1:    rgb_nx = {3{h[7:0]}};
                2'd2:    rgb_nx = {3{cnt_nx[7:0]}};
                default: rgb_nx = {24{h[6] ^ v[6]}};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            h           <= 11'd0;
            v           <= 10'd0;
            pat_q       <= 2'd0;
            out_red     <= 8'h00;
            out_green   <= 8'h00;
            out_blue    <= 8'h00;
            out_hsync   <= 1'b0;
            out_vsync   <= 1'b0;
            out_blank   <= 1'b1;
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
            running     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    h           <= 11'd0;
                    v           <= 10'd0;
                    out_red     <= 8'h00;
                    out_green   <= 8'h00;
                    out_blue    <= 8'h00;
                    out_hsync   <= 1'b0;
                    out_vsync   <= 1'b0;
                    out_blank   <= 1'b1;
                    frame_start <= 1'b0;
                    frame_cnt   <= 16'd0;
                    running     <= enable;
                    if (enable) state <= RUN;
                end
                default: begin
                    h <= h_end ? 11'd0 : h + 11'd1;
                    if (h_end) v <= v_end ? 10'd0 : v + 10'd1;
                    {out_red, out_green, out_blue} <= rgb_nx;
                    out_hsync   <= hsync_nx;
                    out_vsync   <= vsync_nx;
                    out_blank   <= !active;
                    frame_start <= first_px;
                    frame_cnt   <= cnt_nx;
                    running     <= 1'b1;
                    if (first_px) pat_q <= pattern;
                    // STOP lets the frame run out and parks at the origin; re-enable resumes seamlessly
                    if (state == RUN) begin
                        if (!enable) state <= STOP;
                    end else if (enable) begin
                        state <= RUN;
                    end else if (h_end && v_end) begin
                        state   <= IDLE;
                        running <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen, run with a shrunken raster (180x72 total) so whole frames fit the cycle budget.
module tb_video_timing_gen;

    localparam int HT    = 180;
    localparam int VT    = 72;
    localparam int FRAME = HT * VT;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [1:0]  pattern;
    logic [7:0]  out_red;
    logic [7:0]  out_green;
    logic [7:0]  out_blue;
    logic        out_hsync;
    logic        out_vsync;
    logic        out_blank;
    logic        frame_start;
    logic [15:0] frame_cnt;
    logic        running;
    logic [23:0] rgb;

    int tests_run;
    int tests_failed;
    int pos;

    video_timing_gen #(
        .H_ACTIVE(168), .H_FP(4), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(66),  .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .enable(enable),
        .pattern(pattern),
        .out_red(out_red),
        .out_green(out_green),
        .out_blue(out_blue),
        .out_hsync(out_hsync),
        .out_vsync(out_vsync),
        .out_blank(out_blank),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt),
        .running(running)
    );

    assign rgb = {out_red, out_green, out_blue};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v, input logic [1:0] pat_v);
        rstn    = rst_v;
        enable  = en_v;
        pattern = pat_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pos++;
    endtask

    task automatic goto_pos(input int target);
        while (pos < target) tick();
    endtask

    int active_cnt, hs_first, hs_cnt, vs_first, vs_cnt, fs_cnt, low_cnt;
    logic [23:0] rgb_x160, rgb_mid;
    logic        got;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        pos          = 0;
        applyStimulus(1'b0, 1'b0, 2'd0);
        repeat (3) tick();

        checkOutput("reset_blank",   32'(out_blank), 32'd1);
        checkOutput("reset_rgb",     32'(rgb), 32'h000000);
        checkOutput("reset_syncs",   32'({out_hsync, out_vsync, frame_start}), 32'd0);
        checkOutput("reset_cnt",     32'(frame_cnt), 32'd0);
        checkOutput("reset_running", 32'(running), 32'd0);

        // Bars frame: release reset with enable high
        applyStimulus(1'b1, 1'b1, 2'd0);
        tick();
        checkOutput("run_running", 32'(running), 32'd1);
        checkOutput("run_blank_pre", 32'(out_blank), 32'd1);
        tick();
        checkOutput("first_blank", 32'(out_blank), 32'd0);
        checkOutput("first_fs", 32'(frame_start), 32'd1);
        checkOutput("first_cnt", 32'(frame_cnt), 32'd1);
        checkOutput("first_rgb", 32'(rgb), 32'h000000);

        pos = 0;
        active_cnt = 0; hs_first = -1; hs_cnt = 0; rgb_x160 = '0;
        for (int i = 0; i < HT; i++) begin
            if (i > 0) tick();
            if (!out_blank) active_cnt++;
            if (out_hsync) begin
                if (hs_first < 0) hs_first = i;
                hs_cnt++;
            end
            if (i == 160) rgb_x160 = rgb;
        end
        checkOutput("line_active", 32'(active_cnt), 32'd168);
        checkOutput("hsync_start", 32'(hs_first), 32'd172);
        checkOutput("hsync_width", 32'(hs_cnt), 32'd3);
        checkOutput("back_porch", 32'(HT - (hs_first + hs_cnt)), 32'd5);
        checkOutput("bar1_rgb", 32'(rgb_x160), 32'h0000FF);
        tick();
        checkOutput("line_period", 32'({out_blank, frame_start}), 32'd0);

        vs_first = -1; vs_cnt = 0; fs_cnt = 0; rgb_mid = '0;
        while (pos < FRAME - 1) begin
            tick();
            if (out_vsync) begin
                if (vs_first < 0) vs_first = pos;
                vs_cnt++;
            end
            if (frame_start) fs_cnt++;
            if (pos == 10 * HT) pattern = 2'd3;
            if (pos == 11 * HT + 160) rgb_mid = rgb;
        end
        checkOutput("vsync_start", 32'(vs_first), 32'(68 * HT));
        checkOutput("vsync_width", 32'(vs_cnt), 32'(2 * HT));
        checkOutput("no_extra_fs", 32'(fs_cnt), 32'd0);
        checkOutput("bars_kept", 32'(rgb_mid), 32'h0000FF);
        tick();
        checkOutput("frame_period", 32'(frame_start), 32'd1);
        checkOutput("frame2_cnt", 32'(frame_cnt), 32'd2);

        // Checkerboard frame
        pos = 0;
        checkOutput("chk_0_0", 32'(rgb), 32'h000000);
        goto_pos(64);
        checkOutput("chk_64_0", 32'(rgb), 32'hFFFFFF);
        goto_pos(64 * HT);
        checkOutput("chk_0_64", 32'(rgb), 32'hFFFFFF);
        goto_pos(64 * HT + 64);
        checkOutput("chk_64_64", 32'(rgb), 32'h000000);
        pattern = 2'd1;
        goto_pos(65 * HT + 64);
        checkOutput("chk_kept", 32'(rgb), 32'h000000);
        goto_pos(FRAME);
        checkOutput("frame3_fs", 32'(frame_start), 32'd1);
        checkOutput("frame3_cnt", 32'(frame_cnt), 32'd3);

        // Ramp frame, then an asynchronous mid-line reset
        pos = 0;
        goto_pos(100);
        checkOutput("ramp_100", 32'(rgb), 32'h646464);
        goto_pos(165);
        checkOutput("ramp_165", 32'(rgb), 32'hA5A5A5);
        applyStimulus(1'b0, 1'b1, 2'd2);
        #1;
        checkOutput("async_rgb", 32'(rgb), 32'h000000);
        checkOutput("async_blank", 32'(out_blank), 32'd1);
        checkOutput("async_state", 32'({running, frame_cnt}), 32'd0);

        // Grey frames from a fresh start
        applyStimulus(1'b1, 1'b1, 2'd2);
        got = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            got = frame_start;
        end
        checkOutput("grey_start_seen", 32'(got), 32'd1);
        pos = 0;
        checkOutput("grey_f1", 32'(rgb), 32'h010101);
        goto_pos(FRAME);
        checkOutput("grey_f2", 32'(rgb), 32'h020202);
        pos = 0;
        goto_pos(FRAME);
        checkOutput("grey_f3", 32'(rgb), 32'h030303);
        checkOutput("grey_f3_cnt", 32'(frame_cnt), 32'd3);

        pos = 0;
        goto_pos(30 * HT);
        applyStimulus(1'b1, 1'b0, 2'd2);
        tick();
        checkOutput("stop_running", 32'(running), 32'd1);
        goto_pos(65 * HT);
        checkOutput("stop_continues", 32'(out_blank), 32'd0);
        goto_pos(FRAME - 2);
        checkOutput("stop_near_end", 32'(running), 32'd1);
        tick();
        checkOutput("stop_done", 32'({running, out_blank}), 32'b01);

        fs_cnt = 0; low_cnt = 0;
        repeat (400) begin
            tick();
            if (frame_start) fs_cnt++;
            if (!out_blank) low_cnt++;
        end
        checkOutput("idle_no_fs", 32'(fs_cnt), 32'd0);
        checkOutput("idle_blank", 32'(low_cnt), 32'd0);
        checkOutput("idle_cnt", 32'(frame_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
